// File: rtl/mux_8x1.sv
// 8-to-1 lane selector with a 3-bit select split over s1 (MSB), s2, s3 (LSB).
// The output is registered (1-cycle latency) or combinational, set by REG_OUT.
module mux_8x1 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i8,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [2:0]       sel;
  logic [WIDTH-1:0] mux_result;

  assign sel = {s1, s2, s3};

  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    mux_result = '0;
    case (sel)
      3'd0: mux_result = i1;
      3'd1: mux_result = i2;
      3'd2: mux_result = i3;
      3'd3: mux_result = i4;
      3'd4: mux_result = i5;
      3'd5: mux_result = i6;
      3'd6: mux_result = i7;
      3'd7: mux_result = i8;
      default: mux_result = '0;
    endcase
  end

  // out_valid keeps its registered behaviour in both output modes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= '0;
        end else if (en) begin
          out_q <= mux_result;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      assign out = mux_result;
    end
  endgenerate

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: registered 8-bit and 1-bit instances plus a
// combinational 8-bit instance share stimulus, checked against an indexed-array model.
module tb_mux_8x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] sel;
  logic [7:0] d [8];

  logic [7:0] out8, outc;
  logic [0:0] out1;
  logic       v8, v1, vc;

  // Model state for the registered instances.
  logic [7:0] exp8;
  logic       exp1;
  logic       expv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_8x1 #(.WIDTH(8), .REG_OUT(1'b1)) u_reg8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i1(d[0]), .i2(d[1]), .i3(d[2]), .i4(d[3]),
    .i5(d[4]), .i6(d[5]), .i7(d[6]), .i8(d[7]),
    .s1(sel[2]), .s2(sel[1]), .s3(sel[0]),
    .out(out8), .out_valid(v8)
  );

  mux_8x1 #(.WIDTH(1), .REG_OUT(1'b1)) u_reg1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i1(d[0][0]), .i2(d[1][0]), .i3(d[2][0]), .i4(d[3][0]),
    .i5(d[4][0]), .i6(d[5][0]), .i7(d[6][0]), .i8(d[7][0]),
    .s1(sel[2]), .s2(sel[1]), .s3(sel[0]),
    .out(out1), .out_valid(v1)
  );

  mux_8x1 #(.WIDTH(8), .REG_OUT(1'b0)) u_comb8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .i1(d[0]), .i2(d[1]), .i3(d[2]), .i4(d[3]),
    .i5(d[4]), .i6(d[5]), .i7(d[6]), .i8(d[7]),
    .s1(sel[2]), .s2(sel[1]), .s3(sel[0]),
    .out(outc), .out_valid(vc)
  );

  // Advance one clock edge, updating the model with the values sampled at that edge.
  task automatic cycle();
    if (rst_n && en) begin
      exp8 = d[sel];
      exp1 = d[sel][0];
      expv = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp8 = '0;
    exp1 = 1'b0;
    expv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 3'd0;
    for (int k = 0; k < 8; k++) d[k] = 8'h00;
    model_reset();
    #3;
    total++;
    if (out8 !== 8'h00 || v8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: out=%h valid=%b required out=00 valid=0", out8, v8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    d[0]  = 8'hFF;
    cycle();
    total++;
    if (out8 !== 8'hFF || out1 !== 1'b1 || v8 !== 1'b1) begin
      bad++;
      $display("FAIL reset_preload: out8=%h out1=%b valid=%b required FF 1 1", out8, out1, v8);
    end
    // Assert reset mid-cycle; outputs must clear before any clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out8 !== 8'h00 || out1 !== 1'b0 || v8 !== 1'b0 || v1 !== 1'b0 || vc !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: out8=%h out1=%b v8=%b v1=%b vc=%b required all zero",
               out8, out1, v8, v1, vc);
    end
    total++;
    if (outc !== 8'hFF) begin
      bad++;
      $display("FAIL reset_comb_passthrough: out=%h required FF", outc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_select_sweep();
    en = 1'b1;
    for (int k = 0; k < 8; k++) d[k] = (k % 2 == 0) ? 8'h01 : 8'h00;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      total++;
      if (out1 !== ((s % 2 == 0) ? 1'b1 : 1'b0) || v1 !== 1'b1) begin
        bad++;
        $display("FAIL select_sweep sel=%0d: out=%b valid=%b required out=%b valid=1",
                 s, out1, v1, (s % 2 == 0));
      end
    end
  endtask

  task automatic test_walking_one();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) d[j] = (j == k) ? 8'h01 : 8'h00;
      for (int s = 0; s < 8; s++) begin
        sel = 3'(s);
        cycle();
        total++;
        if (out1 !== ((s == k) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL walking_one k=%0d sel=%0d: out=%b required %b", k + 1, s, out1, (s == k));
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    en   = 1'b1;
    sel  = 3'd0;
    d[0] = 8'h01;
    cycle();
    en   = 1'b0;
    sel  = 3'd1;
    d[1] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (out1 !== 1'b1 || v1 !== 1'b1) begin
        bad++;
        $display("FAIL enable_hold cycle=%0d: out=%b valid=%b required 1 1", c, out1, v1);
      end
    end
    en = 1'b1;
    cycle();
    total++;
    if (out1 !== 1'b0) begin
      bad++;
      $display("FAIL enable_release: out=%b required 0", out1);
    end
  endtask

  task automatic test_wide_comb();
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) d[k] = 8'(8'h11 * (k + 1));
    sel = 3'b101;
    #1;
    total++;
    if (outc !== 8'h66) begin
      bad++;
      $display("FAIL comb_select: out=%h required 66", outc);
    end
    d[5] = 8'hA5;
    #1;
    total++;
    if (outc !== 8'hA5) begin
      bad++;
      $display("FAIL comb_data_change: out=%h required A5", outc);
    end
    sel = 3'b000;
    #1;
    total++;
    if (outc !== 8'h11) begin
      bad++;
      $display("FAIL comb_sel_change: out=%h required 11", outc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      sel = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
      #1;
      total++;
      if (outc !== d[sel]) begin
        bad++;
        $display("FAIL random_comb n=%0d: out=%h required %h", n, outc, d[sel]);
      end
      cycle();
      total++;
      if (out8 !== exp8 || out1 !== exp1 || v8 !== expv || v1 !== expv || vc !== expv) begin
        bad++;
        $display("FAIL random_reg n=%0d: out8=%h out1=%b v8=%b v1=%b vc=%b required %h %b %b",
                 n, out8, out1, v8, v1, vc, exp8, exp1, expv);
      end
    end
  endtask

  task automatic test_reset_midop();
    en  = 1'b1;
    sel = 3'd3;
    d[3] = 8'h5A;
    cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    #1;
    total++;
    if (out8 !== 8'h00 || v8 !== 1'b0) begin
      bad++;
      $display("FAIL midop_after_release: out=%h valid=%b required 00 0", out8, v8);
    end
    cycle();
    total++;
    if (out8 !== 8'h00 || v8 !== 1'b0) begin
      bad++;
      $display("FAIL midop_no_en: out=%h valid=%b required 00 0", out8, v8);
    end
    en   = 1'b1;
    sel  = 3'd6;
    d[6] = 8'hC3;
    cycle();
    total++;
    if (out8 !== 8'hC3 || v8 !== 1'b1) begin
      bad++;
      $display("FAIL midop_first_load: out=%h valid=%b required C3 1", out8, v8);
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_walking_one();
    test_enable_hold();
    test_wide_comb();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
